// File: rtl/ntt_bitrev_reorder.sv
// Ping-pong frame buffer that re-emits each N-word coefficient frame in natural or
// bit-reversed order, selected per frame by the mode sampled on the frame's first word.
module ntt_bitrev_reorder #(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned N      = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bitrev_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        bank_full
);

    localparam int unsigned AW = $clog2(N);
    typedef logic [AW-1:0] idx_t;

    logic [DATA_W-1:0] mem [2*N];

    logic [1:0]        full_q, full_d;
    logic [1:0]        mode_q, mode_d;
    logic              wr_bank_q, wr_bank_d;
    idx_t              wr_idx_q, wr_idx_d;
    logic              rd_bank_q, rd_bank_d;
    idx_t              rd_idx_q, rd_idx_d;
    logic              out_bank_q, out_bank_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q;

    logic wr_fire;
    logic wr_done;
    logic out_fire;
    logic fetch;
    idx_t rd_rev;
    idx_t rd_addr;

    assign in_ready  = reset && !full_q[wr_bank_q];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign bank_full = full_q;

    always_comb begin
        rd_rev = '0;
        for (int b = 0; b < int'(AW); b++) begin
            rd_rev[b] = rd_idx_q[int'(AW) - 1 - b];
        end
        rd_addr = mode_q[rd_bank_q] ? rd_rev : rd_idx_q;
    end

    always_comb begin
        wr_fire  = in_valid && in_ready;
        wr_done  = wr_fire && (wr_idx_q == idx_t'(N - 1));
        out_fire = out_valid_q && out_ready;
        // A bank completing this cycle may be fetched at once: output index 0 reads address 0
        // in either mode, which was written long before the final word arrives.
        fetch    = (full_q[rd_bank_q] || (wr_done && (wr_bank_q == rd_bank_q)))
                   && (!out_valid_q || out_ready);
    end

    always_comb begin
        full_d      = full_q;
        mode_d      = mode_q;
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        out_bank_d  = out_bank_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_fire && out_last_q) begin
            full_d[out_bank_q] = 1'b0;
        end
        if (wr_fire) begin
            if (wr_idx_q == '0) begin
                mode_d[wr_bank_q] = bitrev_en;
            end
            if (wr_done) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_idx_d          = '0;
            end else begin
                wr_idx_d = wr_idx_q + idx_t'(1);
            end
        end

        if (fetch) begin
            out_valid_d = 1'b1;
            out_bank_d  = rd_bank_q;
            out_last_d  = (rd_idx_q == idx_t'(N - 1));
            if (rd_idx_q == idx_t'(N - 1)) begin
                rd_bank_d = !rd_bank_q;
                rd_idx_d  = '0;
            end else begin
                rd_idx_d = rd_idx_q + idx_t'(1);
            end
        end else if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank_q, wr_idx_q}] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full_q      <= '0;
            mode_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_idx_q    <= '0;
            out_bank_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            full_q      <= full_d;
            mode_q      <= mode_d;
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_bank_q   <= rd_bank_d;
            rd_idx_q    <= rd_idx_d;
            out_bank_q  <= out_bank_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            if (fetch) begin
                out_data_q <= mem[{rd_bank_q, rd_addr}];
            end
        end
    end

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// Randomized directed bench for ntt_bitrev_reorder at N=8 and N=16 against a queue-based
// model of frame capture and (bit-reversed) re-emission.
module tb_ntt_bitrev_reorder;

    localparam int unsigned W = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         iv    [2];
    logic         ir    [2];
    logic [W-1:0] idat  [2];
    logic         ben   [2];
    logic         ov    [2];
    logic         ordy  [2];
    logic [W-1:0] odat  [2];
    logic         olast [2];
    logic [1:0]   bf    [2];

    ntt_bitrev_reorder #(.DATA_W(W), .N(8)) u_n8 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
        .bitrev_en(ben[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odat[0]),
        .out_last(olast[0]), .bank_full(bf[0])
    );

    ntt_bitrev_reorder #(.DATA_W(W), .N(16)) u_n16 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
        .bitrev_en(ben[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odat[1]),
        .out_last(olast[1]), .bank_full(bf[1])
    );

    int tests = 0;
    int fails = 0;

    // Model state
    int   src_q[$];
    logic fm_q[$];
    int   frame_buf[$];
    int   exp_q[$];
    logic exp_last[$];
    int   acc_cnt;
    logic cur_mode;

    // Per-run observations
    int   got_q[$];
    int   n_acc, n_beats, gaps, stalls, t_last_in, t_first_out;
    logic timed_out;

    function automatic int nsize(input int d);
        return (d == 0) ? 8 : 16;
    endfunction

    function automatic int rev(input int i, input int n);
        int r = 0;
        int v = i;
        int m = n;
        while (m > 1) begin
            r = r * 2 + v % 2;
            v = v / 2;
            m = m / 2;
        end
        return r;
    endfunction

    function automatic void model_accept(input int d, input int word, input logic mode_in);
        int n = nsize(d);
        if (acc_cnt % n == 0) cur_mode = mode_in;
        frame_buf.push_back(word);
        acc_cnt++;
        if (frame_buf.size() == n) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(frame_buf[cur_mode ? rev(i, n) : i]);
                exp_last.push_back(i == n - 1);
            end
            frame_buf.delete();
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; ben[d] = 1'b0; idat[d] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_in_ready", ir[0], 0);
        check("rst_out_valid", ov[0], 0);
        check("rst_out_data", odat[0], 0);
        check("rst_out_last", olast[0], 0);
        check("rst_bank_full", bf[0], 0);
        check("rst_bank_full_n16", bf[1], 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", ir[0], 1);
        check("post_rst_in_ready_n16", ir[1], 1);
        acc_cnt = 0;
        src_q.delete(); fm_q.delete(); frame_buf.delete(); exp_q.delete(); exp_last.delete();
    endtask

    // pol: 0 = out_ready low, 1 = out_ready high, 2 = random out_ready
    task automatic run(input int d, input int pol, input int budget);
        int   n = nsize(d);
        int   cyc = 0;
        logic m;
        n_acc = 0; n_beats = 0; gaps = 0; stalls = 0; t_last_in = -1; t_first_out = -1;
        got_q.delete();
        while (cyc < budget && (src_q.size() > 0 || exp_q.size() > 0)) begin
            iv[d]   = (src_q.size() > 0);
            idat[d] = (src_q.size() > 0) ? W'(src_q[0]) : W'($urandom);
            m = (acc_cnt % n == 0 && fm_q.size() > 0) ? fm_q[0] : logic'($urandom % 2);
            ben[d]  = m;
            ordy[d] = (pol == 0) ? 1'b0 : (pol == 1) ? 1'b1 : logic'($urandom % 2);
            #1;
            if (ov[d] && t_last_in >= 0 && t_first_out < 0) t_first_out = cyc;
            if (n_beats > 0 && !ov[d]) gaps++;
            if (ov[d] && ordy[d]) begin
                n_beats++;
                got_q.push_back(int'(odat[d]));
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 1, 0);
                end else begin
                    check("beat_data", odat[d], exp_q.pop_front());
                    check("beat_last", olast[d], exp_last.pop_front());
                end
            end
            if (iv[d]) begin
                if (ir[d]) begin
                    if (acc_cnt % n == 0 && fm_q.size() > 0) void'(fm_q.pop_front());
                    model_accept(d, src_q.pop_front(), m);
                    n_acc++;
                    if (acc_cnt % n == 0 && t_last_in < 0) t_last_in = cyc;
                end else begin
                    stalls++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        timed_out = (src_q.size() > 0 || exp_q.size() > 0);
        iv[d] = 1'b0;
    endtask

    initial begin
        int lit[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int idle_valid;

        do_reset();

        // Bit-reversed frame 0..7
        for (int i = 0; i < 8; i++) src_q.push_back(i);
        fm_q.push_back(1'b1);
        run(0, 1, 60);
        check("s1_timeout", timed_out, 0);
        check("s1_beats", n_beats, 8);
        for (int i = 0; i < 8; i++) check("s1_literal", got_q[i], lit[i]);

        // Natural order, first output latency
        do_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(32'h1E00 + i);
        fm_q.push_back(1'b0);
        run(0, 1, 60);
        check("s2_timeout", timed_out, 0);
        check("s2_latency_ok", (t_first_out >= 0) && (t_first_out - t_last_in <= 2), 1);
        for (int i = 0; i < 8; i++) check("s2_literal", got_q[i], 32'h1E00 + i);

        // Backpressure: both banks fill, then drain
        do_reset();
        for (int i = 0; i < 24; i++) src_q.push_back(int'($urandom % 8192));
        fm_q.push_back(1'b1); fm_q.push_back(1'b0); fm_q.push_back(1'b1);
        run(0, 0, 40);
        check("s3_accepted", n_acc, 16);
        check("s3_in_ready", ir[0], 0);
        check("s3_bank_full", bf[0], 2'b11);
        run(0, 1, 120);
        check("s3_timeout", timed_out, 0);
        check("s3_rest_accepted", n_acc, 8);
        check("s3_beats", n_beats, 24);

        // N=16, four back-to-back frames, alternating mode
        do_reset();
        for (int i = 0; i < 64; i++) src_q.push_back(int'($urandom % 8192));
        fm_q.push_back(1'b1); fm_q.push_back(1'b0); fm_q.push_back(1'b1); fm_q.push_back(1'b0);
        run(1, 1, 200);
        check("s4_timeout", timed_out, 0);
        check("s4_beats", n_beats, 64);
        check("s4_out_gaps", gaps, 0);
        check("s4_in_stalls", stalls, 0);

        // Random out_ready, same frame as the first case
        do_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(i);
        fm_q.push_back(1'b1);
        run(0, 2, 200);
        check("s5_timeout", timed_out, 0);
        check("s5_beats", n_beats, 8);
        for (int i = 0; i < 8; i++) check("s5_literal", got_q[i], lit[i]);

        // Longer random traffic with random modes
        for (int i = 0; i < 40; i++) src_q.push_back(int'($urandom % 8192));
        for (int f = 0; f < 5; f++) fm_q.push_back(logic'($urandom % 2));
        run(0, 2, 600);
        check("s5b_timeout", timed_out, 0);
        check("s5b_beats", n_beats, 40);

        // Reset mid-frame discards the partial frame
        do_reset();
        for (int i = 0; i < 5; i++) src_q.push_back(100 + i);
        fm_q.push_back(1'b1);
        run(0, 1, 20);
        check("s6_partial_accepted", n_acc, 5);
        do_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(i);
        fm_q.push_back(1'b1);
        run(0, 1, 60);
        check("s6_timeout", timed_out, 0);
        check("s6_beats", n_beats, 8);
        for (int i = 0; i < 8; i++) check("s6_literal", got_q[i], lit[i]);
        ordy[0] = 1'b1;
        idle_valid = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov[0]) idle_valid++;
        end
        check("s6_no_stale", idle_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
